multi_corr_v7: RTL and testbench

Parametrised successor to the v6 single correlator for the GLITC trigger path. Each clock it takes DEMUX samples from each of NCHAN channels and computes CORR = Σ over slots of (Σ over channels sample)². CORR is delivered through a fixed-latency valid-tagged pipeline. The block also provides an optional windowed accumulator with threshold trigger, and feeds the per-sector trigger logic.

---
 rtl/multi_corr_v7_if.sv | 33 +++
 rtl/multi_corr_v7.sv | 180 ++++++++++++++++++
 tb/tb_multi_corr_v7.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_corr_v7_if.sv
// Sample/result bundle for multi_corr_v7.
// master: sample source and trigger consumer (drives IN, in_valid, acc_clr, THRESH).
// slave : correlator (drives CORR, corr_valid, ACC, acc_valid, trig).
interface multi_corr_v7_if #(
    parameter int unsigned NCHAN    = 3,
    parameter int unsigned NBITS    = 3,
    parameter int unsigned DEMUX    = 16,
    parameter int unsigned ACC_LOG2 = 3
);
    localparam int unsigned INW = NCHAN * DEMUX * NBITS;
    localparam int unsigned CW  = $clog2(DEMUX * NCHAN * NCHAN * (2 ** (2 * NBITS - 2)) + 1);
    localparam int unsigned AW  = CW + ACC_LOG2;

    logic [INW-1:0] IN;
    logic           in_valid;
    logic           acc_clr;
    logic [AW-1:0]  THRESH;
    logic [CW-1:0]  CORR;
    logic           corr_valid;
    logic [AW-1:0]  ACC;
    logic           acc_valid;
    logic           trig;

    modport master (
        output IN, in_valid, acc_clr, THRESH,
        input  CORR, corr_valid, ACC, acc_valid, trig
    );

    modport slave (
        input  IN, in_valid, acc_clr, THRESH,
        output CORR, corr_valid, ACC, acc_valid, trig
    );
endinterface

// File: rtl/multi_corr_v7.sv
// Multi-channel correlator: CORR = sum over slots of (sum over channels sample)^2,
// delivered through a fixed-latency valid-tagged pipeline, plus an optional
// windowed accumulator with threshold trigger (macro CORR_ACC_EN).
// Ports: clk, rst_n (async active-low), bus (multi_corr_v7_if.slave):
//   IN/in_valid samples in, acc_clr/THRESH accumulator control,
//   CORR/corr_valid result, ACC/acc_valid window sum, trig threshold pulse.
// Without CORR_ACC_EN, ACC/acc_valid are tied to 0 and trig compares CORR itself.
module multi_corr_v7 #(
    parameter int unsigned NCHAN    = 3,
    parameter int unsigned NBITS    = 3,
    parameter int unsigned DEMUX    = 16,
    parameter int unsigned DELAY    = 0,
    parameter int unsigned ACC_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    multi_corr_v7_if.slave   bus
);
    localparam int unsigned INW   = NCHAN * DEMUX * NBITS;
    localparam int unsigned CW    = $clog2(DEMUX * NCHAN * NCHAN * (2 ** (2 * NBITS - 2)) + 1);
    localparam int unsigned AW    = CW + ACC_LOG2;
    localparam int unsigned SW    = NBITS + 2;
    localparam int unsigned LOG2D = $clog2(DEMUX);
    localparam int unsigned TL    = (LOG2D + 1) / 2;
    localparam bit          ODD   = (LOG2D % 2) == 1;
    localparam int unsigned NV    = 3 + TL + DELAY;

    logic [INW-1:0]        in_q, in_d;
    logic signed [SW-1:0]  sum_q  [DEMUX];
    logic signed [SW-1:0]  sum_d  [DEMUX];
    // Level 0 holds the squares, levels 1..TL the adder tree; node 0 of level TL is the result.
    logic [CW-1:0]         tree_q [TL+1][DEMUX];
    logic [CW-1:0]         tree_d [TL+1][DEMUX];
    logic [NV-1:0]         vld_q, vld_d;
    logic [CW-1:0]         pad    [4*DEMUX];

    // Datapath next-state: channel sums, squares and radix-4 tree levels.
    always_comb begin
        in_d = bus.IN;
        for (int unsigned s = 0; s < DEMUX; s++) begin
            logic signed [SW-1:0] acc_s;
            acc_s = '0;
            for (int unsigned c = 0; c < NCHAN; c++) begin
                acc_s = acc_s + SW'($signed(in_q[(c * DEMUX + s) * NBITS +: NBITS]));
            end
            sum_d[s] = acc_s;
        end
        for (int unsigned s = 0; s < DEMUX; s++) begin
            logic signed [2*SW-1:0] sq;
            sq = sum_q[s] * sum_q[s];
            tree_d[0][s] = CW'($unsigned(sq));
        end
        for (int unsigned i = 0; i < 4 * DEMUX; i++) pad[i] = '0;
        for (int unsigned l = 1; l <= TL; l++) begin
            // Zero-padded copy of the previous level keeps every 4j+k index in range.
            for (int unsigned i = 0; i < 4 * DEMUX; i++) pad[i] = '0;
            for (int unsigned i = 0; i < DEMUX; i++) pad[i] = tree_q[l-1][i];
            for (int unsigned j = 0; j < DEMUX; j++) begin
                tree_d[l][j] = pad[4*j] + pad[4*j+1];
                if (!(ODD && (l == TL))) begin
                    tree_d[l][j] = tree_d[l][j] + pad[4*j+2] + pad[4*j+3];
                end
            end
        end
        vld_d = {vld_q[NV-2:0], bus.in_valid};
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q  <= '0;
            vld_q <= '0;
            for (int unsigned s = 0; s < DEMUX; s++) sum_q[s] <= '0;
            for (int unsigned l = 0; l <= TL; l++) begin
                for (int unsigned j = 0; j < DEMUX; j++) tree_q[l][j] <= '0;
            end
        end else begin
            in_q  <= in_d;
            vld_q <= vld_d;
            sum_q <= sum_d;
            tree_q <= tree_d;
        end
    end

    // Optional pass-through stages after the tree.
    if (DELAY > 0) begin : g_dly
        logic [CW-1:0] dly_q [DELAY];
        logic [CW-1:0] dly_d [DELAY];

        always_comb begin
            dly_d[0] = tree_q[TL][0];
            for (int unsigned i = 1; i < DELAY; i++) dly_d[i] = dly_q[i-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < DELAY; i++) dly_q[i] <= '0;
            end else begin
                dly_q <= dly_d;
            end
        end

        assign bus.CORR = dly_q[DELAY-1];
    end else begin : g_nodly
        assign bus.CORR = tree_q[TL][0];
    end

    assign bus.corr_valid = vld_q[NV-1];

    logic trig_q, trig_d;

`ifdef CORR_ACC_EN
    logic [AW-1:0]       acc_sum_q, acc_sum_d;
    logic [ACC_LOG2-1:0] cnt_q, cnt_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic                acc_valid_q, acc_valid_d;
    logic [AW-1:0]       total_c;

    // Window accumulation; clear beats a coincident completing sample.
    always_comb begin
        acc_sum_d   = acc_sum_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        acc_valid_d = 1'b0;
        trig_d      = 1'b0;
        total_c     = acc_sum_q + AW'(bus.CORR);
        if (bus.acc_clr) begin
            acc_sum_d = '0;
            cnt_d     = '0;
        end else if (bus.corr_valid) begin
            cnt_d = cnt_q + ACC_LOG2'(1);
            if (cnt_q == {ACC_LOG2{1'b1}}) begin
                acc_d       = total_c;
                acc_valid_d = 1'b1;
                trig_d      = total_c > bus.THRESH;
                acc_sum_d   = '0;
            end else begin
                acc_sum_d = total_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_q   <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            acc_sum_q   <= acc_sum_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            trig_q      <= trig_d;
        end
    end

    assign bus.ACC       = acc_q;
    assign bus.acc_valid = acc_valid_q;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = bus.acc_clr;

    // Per-result threshold pulse when no accumulator is built.
    always_comb begin
        trig_d = bus.corr_valid && (AW'(bus.CORR) > bus.THRESH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_q <= 1'b0;
        else        trig_q <= trig_d;
    end

    assign bus.ACC       = '0;
    assign bus.acc_valid = 1'b0;
`endif

    assign bus.trig = trig_q;
endmodule

// File: tb/tb_multi_corr_v7.sv
// Self-checking bench for multi_corr_v7 at default parameters: vector table,
// hand sequences for windows/clear/reset, and random traffic against a
// cycle-level reference model (latency delay line + window arithmetic).
module tb_multi_corr_v7;
    localparam int unsigned NCHAN    = 3;
    localparam int unsigned NBITS    = 3;
    localparam int unsigned DEMUX    = 16;
    localparam int unsigned DELAY    = 0;
    localparam int unsigned ACC_LOG2 = 3;
    localparam int unsigned INW      = NCHAN * DEMUX * NBITS;
    localparam int unsigned AW       = 15;
    localparam int          L        = 5;
    localparam int          WIN      = 8;
    localparam int          MAXC     = 8192;

    logic clk;
    logic rst_n;

    multi_corr_v7_if #(.NCHAN(NCHAN), .NBITS(NBITS), .DEMUX(DEMUX), .ACC_LOG2(ACC_LOG2)) bus ();

    multi_corr_v7 #(
        .NCHAN(NCHAN), .NBITS(NBITS), .DEMUX(DEMUX), .DELAY(DELAY), .ACC_LOG2(ACC_LOG2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int c;
        bit s0;
        int corr;
    } vec_t;

    vec_t tbl [9];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit hv [MAXC];
    int hc [MAXC];
    bit pv, ev, eav, etr;
    int pc, ec, m_sum, m_cnt, m_acc;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // CORR straight from its definition.
    function automatic int model_corr(logic [INW-1:0] x);
        int tot = 0;
        for (int s = 0; s < int'(DEMUX); s++) begin
            int ss = 0;
            for (int c = 0; c < int'(NCHAN); c++) begin
                logic signed [NBITS-1:0] f;
                f = x[(c * DEMUX + s) * NBITS +: NBITS];
                ss += int'(f);
            end
            tot += ss * ss;
        end
        return tot;
    endfunction

    function automatic logic [INW-1:0] mk(int a, int b, int c3, bit s0);
        logic [INW-1:0] x;
        int smp [3];
        smp = '{a, b, c3};
        x = '0;
        for (int c = 0; c < int'(NCHAN); c++)
            for (int s = 0; s < int'(DEMUX); s++)
                x[(c * DEMUX + s) * NBITS +: NBITS] = (s0 && s != 0) ? NBITS'(0) : NBITS'(smp[c]);
        return x;
    endfunction

    task automatic drive(logic [INW-1:0] x, bit v);
        bus.IN       = x;
        bus.in_valid = v;
    endtask

    // One clock: record the sampled inputs, advance the model, compare outputs.
    task automatic tick();
        int thr_s;
`ifdef CORR_ACC_EN
        bit clr_s;
`endif
        @(posedge clk);
        cyc++;
        thr_s = int'(bus.THRESH);
`ifdef CORR_ACC_EN
        clr_s = bus.acc_clr;
`endif
        eav = 1'b0;
        etr = 1'b0;
        if (!rst_n) begin
            hv[cyc % MAXC] = 1'b0;
            hc[cyc % MAXC] = 0;
            m_sum = 0; m_cnt = 0; m_acc = 0;
        end else begin
            hv[cyc % MAXC] = bus.in_valid;
            hc[cyc % MAXC] = model_corr(bus.IN);
`ifdef CORR_ACC_EN
            if (clr_s) begin
                m_sum = 0; m_cnt = 0;
            end else if (pv) begin
                m_sum += pc;
                m_cnt++;
                if (m_cnt == WIN) begin
                    m_acc = m_sum;
                    eav   = 1'b1;
                    etr   = m_acc > thr_s;
                    m_sum = 0; m_cnt = 0;
                end
            end
`else
            etr = pv && (pc > thr_s);
`endif
        end
        #1;
        ev = 1'b0;
        ec = 0;
        if (rst_n && cyc >= L - 1) begin
            ev = hv[(cyc - (L - 1)) % MAXC];
            ec = hc[(cyc - (L - 1)) % MAXC];
        end
        chk("corr_valid", int'(bus.corr_valid), int'(ev));
        if (ev) chk("corr", int'(bus.CORR), ec);
        chk("acc_valid", int'(bus.acc_valid), int'(eav));
        chk("acc", int'(bus.ACC), m_acc);
        chk("trig", int'(bus.trig), int'(etr));
        pv = ev;
        pc = ec;
    endtask

    // Called one tick after a single valid sample; checks its latency and value.
    task automatic measure(int exp_corr, string tag);
        int lat;
        lat = 1;
        bus.in_valid = 1'b0;
        while (!bus.corr_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, L);
        chk({tag, "_corr"}, int'(bus.CORR), exp_corr);
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            hv[i] = 1'b0;
            hc[i] = 0;
        end
        m_sum = 0; m_cnt = 0; m_acc = 0; pv = 1'b0; pc = 0;
        #1;
        chk("rst_corr", int'(bus.CORR), 0);
        chk("rst_corr_valid", int'(bus.corr_valid), 0);
        chk("rst_acc", int'(bus.ACC), 0);
        chk("rst_acc_valid", int'(bus.acc_valid), 0);
        chk("rst_trig", int'(bus.trig), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [INW-1:0] rx;
        int first, second, npulse, nval, clr_edge, av_cyc;

        tbl[0] = '{0, 0, 0, 1'b0, 0};
        tbl[1] = '{1, 1, 1, 1'b1, 9};
        tbl[2] = '{-4, -4, -4, 1'b0, 2304};
        tbl[3] = '{3, -3, 0, 1'b0, 0};
        tbl[4] = '{1, 1, 1, 1'b0, 144};
        tbl[5] = '{3, 3, 3, 1'b0, 1296};
        tbl[6] = '{-4, 3, 0, 1'b0, 16};
        tbl[7] = '{3, 3, -4, 1'b0, 64};
        tbl[8] = '{-4, -4, -4, 1'b1, 144};

        pv = 1'b0; pc = 0; m_sum = 0; m_cnt = 0; m_acc = 0;
        bus.IN = '0; bus.in_valid = 1'b0; bus.acc_clr = 1'b0; bus.THRESH = '0;
        rst_n = 1'b1;
        #1;
        reset_mid();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Vector table: one isolated sample each.
        for (int i = 0; i < 9; i++) begin
            drive(mk(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s0), 1'b1);
            tick();
            measure(tbl[i].corr, $sformatf("vec%0d", i));
            tick();
        end

`ifdef CORR_ACC_EN
        // Window of eight CORR=9 samples with gaps, threshold just below and at the sum.
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        for (int t = 0; t < 2; t++) begin
            int n;
            bus.THRESH = AW'(71 + t);
            for (int k = 0; k < 8; k++) begin
                drive(mk(1, 1, 1, 1'b1), 1'b1);
                tick();
                drive('0, 1'b0);
                tick();
            end
            n = 0;
            while (!bus.acc_valid && n < 30) begin
                tick();
                n++;
            end
            chk($sformatf("gap_win%0d_acc_valid", t), int'(bus.acc_valid), 1);
            chk($sformatf("gap_win%0d_acc", t), int'(bus.ACC), 72);
            chk($sformatf("gap_win%0d_trig", t), int'(bus.trig), (t == 0) ? 1 : 0);
        end

        // Sixteen back-to-back samples give two pulses eight cycles apart.
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        first = -1; second = -1; npulse = 0;
        for (int k = 0; k < 40; k++) begin
            drive(mk(1, 1, 1, 1'b1), k < 16);
            tick();
            if (bus.acc_valid) begin
                npulse++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        chk("b2b_pulses", npulse, 2);
        chk("b2b_spacing", second - first, 8);

        // Clear on the fifth output sample restarts the window; ACC holds meanwhile.
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        nval = 0; clr_edge = -1; av_cyc = -1;
        for (int k = 0; k < 50; k++) begin
            drive(mk(1, 1, 1, 1'b1), k < 20);
            tick();
            bus.acc_clr = 1'b0;
            if (clr_edge >= 0 && av_cyc < 0) begin
                if (bus.acc_valid) av_cyc = cyc;
                else chk("clr_acc_hold", int'(bus.ACC), 72);
            end
            if (bus.corr_valid) begin
                nval++;
                if (nval == 5) begin
                    bus.acc_clr = 1'b1;
                    clr_edge = cyc + 1;
                end
            end
        end
        chk("clr_gap", av_cyc - clr_edge, 8);
`endif

        // Reset two cycles after a valid sample: in-flight data must vanish.
        drive(mk(-4, -4, -4, 1'b0), 1'b1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        #2;
        reset_mid();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < L + 2; k++) tick();
        drive(mk(1, 1, 1, 1'b0), 1'b1);
        tick();
        measure(144, "post_rst");
        tick();

`ifndef CORR_ACC_EN
        // Per-result trigger: strict compare at full scale.
        for (int t = 0; t < 2; t++) begin
            bus.THRESH = AW'(2303 + t);
            drive(mk(-4, -4, -4, 1'b0), 1'b1);
            tick();
            measure(2304, $sformatf("fs%0d", t));
            tick();
            chk($sformatf("fs%0d_trig", t), int'(bus.trig), (t == 0) ? 1 : 0);
            tick();
            chk($sformatf("fs%0d_trig_end", t), int'(bus.trig), 0);
        end
`endif

        // Random traffic with an occasional clear and one mid-run reset.
        for (int k = 0; k < 400; k++) begin
            rx = '0;
            for (int f = 0; f < int'(NCHAN * DEMUX); f++) rx[f * NBITS +: NBITS] = NBITS'($urandom);
            drive(rx, ($urandom % 4) != 0);
            bus.acc_clr = ($urandom % 40) == 0;
            bus.THRESH  = AW'($urandom_range(0, 6000));
            if (k == 200) begin
                reset_mid();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        bus.acc_clr = 1'b0;
        drive('0, 1'b0);
        for (int k = 0; k < L + 3; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
